fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined datapath. Owns the PC, issues instruction reads to the icache, and loads the IF/ID pipeline register. It stalls on hazard-unit `hazard` and squashes or redirects on `branch`/`jump`. It feeds `instrOp`/`instrFunc` of the IF/ID instruction straight back to the hazard unit.

---
 rtl/cpu_types_pkg.sv | 46 ++++
 rtl/fetch_if.sv | 31 +++
 rtl/pipe_ifid.sv | 24 ++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared datapath types: instruction fields, fetch FSM states and the IF/ID latch layout.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    localparam int OP_W   = 6;
    localparam int FUNC_W = 6;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [OP_W-1:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [FUNC_W-1:0] {
        SLL = 6'h00,
        SRL = 6'h02,
        JR  = 6'h08,
        ADD = 6'h20,
        SUB = 6'h22
    } funct_t;

    typedef enum logic [1:0] {
        FETCH,
        DROP,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic  valid;
        word_t instr;
        word_t pc;
        word_t npc;
    } ifid_t;

    localparam word_t ALIGN_MASK = 32'hFFFF_FFFC;

    // Redirect targets are word addresses; low two bits are never honoured.
    function automatic word_t align(input word_t a);
        return a & ALIGN_MASK;
    endfunction
endpackage

// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage and its neighbours (icache, hazard unit, decode).
interface fetch_if;
    import cpu_types_pkg::*;

    logic    ihit;
    word_t   imemload;
    logic    hazard;
    logic    branch;
    logic    jump;
    word_t   branch_target;
    word_t   jump_target;
    logic    halt;
    logic    imemREN;
    word_t   imemaddr;
    logic    ifid_valid;
    word_t   ifid_instr;
    word_t   ifid_pc;
    word_t   ifid_npc;
    opcode_t instrOp;
    funct_t  instrFunc;

    modport fs (
        input  ihit, imemload, hazard, branch, jump, branch_target, jump_target, halt,
        output imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc, instrOp, instrFunc
    );

    modport tb (
        output ihit, imemload, hazard, branch, jump, branch_target, jump_target, halt,
        input  imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc, instrOp, instrFunc
    );
endinterface

// File: rtl/pipe_ifid.sv
// IF/ID pipeline latch: flush loads a bubble (all zero) and beats en; en=0 holds.
module pipe_ifid
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  en,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);
    ifid_t r_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_q <= '0;
        else if (flush)
            r_q <= '0;
        else if (en)
            r_q <= d;
    end

    assign q = r_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the icache read and loads IF/ID.
// A redirect that lands on a pending miss is parked in r_redir until the stale access completes.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic    CLK,
    input  logic    nRST,
    input  logic    ihit,
    input  word_t   imemload,
    input  logic    hazard,
    input  logic    branch,
    input  logic    jump,
    input  word_t   branch_target,
    input  word_t   jump_target,
    input  logic    halt,
    output logic    imemREN,
    output word_t   imemaddr,
    output logic    ifid_valid,
    output word_t   ifid_instr,
    output word_t   ifid_pc,
    output word_t   ifid_npc,
    output opcode_t instrOp,
    output funct_t  instrFunc
);
    fetch_state_t r_state, w_state_nxt;
    word_t        r_pc, w_pc_nxt;
    word_t        r_redir, w_redir_nxt;
    word_t        w_pc_inc;
    word_t        w_target;
    logic         w_redirect;
    logic         w_ifid_en;
    logic         w_ifid_flush;
    ifid_t        w_ifid_d;
    ifid_t        w_ifid_q;

    assign w_pc_inc   = r_pc + 32'd4;
    assign w_redirect = jump | branch;
    assign w_target   = align(jump ? jump_target : branch_target);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FETCH;
            r_pc    <= PC_INIT;
            r_redir <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_redir <= w_redir_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_redir_nxt  = r_redir;
        w_ifid_en    = 1'b0;
        w_ifid_flush = 1'b0;
        case (r_state)
            FETCH: begin
                if (halt) begin
                    w_state_nxt  = HALTED;
                    w_ifid_flush = 1'b1;
                end else if (w_redirect) begin
                    w_ifid_flush = 1'b1;
                    if (ihit) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_redir_nxt = w_target;
                        w_state_nxt = DROP;
                    end
                end else if (hazard) begin
                    // Hold PC and IF/ID; a hit this cycle is simply refetched.
                    w_ifid_en = 1'b0;
                end else if (ihit) begin
                    w_pc_nxt  = w_pc_inc;
                    w_ifid_en = 1'b1;
                end else begin
                    w_ifid_flush = 1'b1;
                end
            end
            DROP: begin
                w_ifid_flush = 1'b1;
                if (halt) begin
                    w_state_nxt = HALTED;
                end else begin
                    if (w_redirect)
                        w_redir_nxt = w_target;
                    // Stale miss finished: its data is dropped and the latest target taken.
                    if (ihit) begin
                        w_pc_nxt    = w_redirect ? w_target : r_redir;
                        w_state_nxt = FETCH;
                    end
                end
            end
            HALTED: begin
                w_ifid_flush = 1'b1;
            end
            default: begin
                w_state_nxt  = FETCH;
                w_ifid_flush = 1'b1;
            end
        endcase
    end

    assign w_ifid_d = '{valid: 1'b1, instr: imemload, pc: r_pc, npc: w_pc_inc};

    pipe_ifid u_ifid (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (w_ifid_en),
        .flush (w_ifid_flush),
        .d     (w_ifid_d),
        .q     (w_ifid_q)
    );

    // Address is a pure function of PC so the icache never sees ihit feed back.
    assign imemREN    = nRST && (r_state != HALTED);
    assign imemaddr   = r_pc;
    assign ifid_valid = w_ifid_q.valid;
    assign ifid_instr = w_ifid_q.instr;
    assign ifid_pc    = w_ifid_q.pc;
    assign ifid_npc   = w_ifid_q.npc;
    assign instrOp    = opcode_t'(w_ifid_q.instr[31:26]);
    assign instrFunc  = funct_t'(w_ifid_q.instr[5:0]);
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID contents are queued per cycle and checked after the edge.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    logic mem_const;
    int   ntests;
    int   nfail;

    ifid_t exp_q[$];
    ifid_t last_exp;

    fetch_if fif ();

    function automatic word_t memword(input word_t a);
        if (mem_const)
            return 32'h2001_0005;
        return {6'h08, 5'd1, 5'd1, a[15:0]};
    endfunction

    assign fif.imemload = memword(fif.imemaddr);

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .ihit          (fif.ihit),
        .imemload      (fif.imemload),
        .hazard        (fif.hazard),
        .branch        (fif.branch),
        .jump          (fif.jump),
        .branch_target (fif.branch_target),
        .jump_target   (fif.jump_target),
        .halt          (fif.halt),
        .imemREN       (fif.imemREN),
        .imemaddr      (fif.imemaddr),
        .ifid_valid    (fif.ifid_valid),
        .ifid_instr    (fif.ifid_instr),
        .ifid_pc       (fif.ifid_pc),
        .ifid_npc      (fif.ifid_npc),
        .instrOp       (fif.instrOp),
        .instrFunc     (fif.instrFunc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // kind: 0 bubble, 1 valid fetch of pc p, 2 IF/ID held
    task automatic step(input string tag, input word_t a, input logic ren, input int kind, input word_t p);
        ifid_t e;
        ifid_t g;
        #1;
        chk({tag, "_addr"}, fif.imemaddr, a);
        chk({tag, "_ren"}, fif.imemREN, ren);
        case (kind)
            1:       e = '{valid: 1'b1, instr: memword(p), pc: p, npc: p + 32'd4};
            2:       e = last_exp;
            default: e = '0;
        endcase
        exp_q.push_back(e);
        last_exp = e;
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        g = '{valid: fif.ifid_valid, instr: fif.ifid_instr, pc: fif.ifid_pc, npc: fif.ifid_npc};
        chk({tag, "_ifid"}, g, e);
        chk({tag, "_opfn"}, {fif.instrOp, fif.instrFunc}, {e.instr[31:26], e.instr[5:0]});
    endtask

    task automatic rst_checks(input string tag);
        ifid_t g;
        g = '{valid: fif.ifid_valid, instr: fif.ifid_instr, pc: fif.ifid_pc, npc: fif.ifid_npc};
        chk({tag, "_ren"}, fif.imemREN, 1'b0);
        chk({tag, "_addr"}, fif.imemaddr, 32'h0);
        chk({tag, "_ifid"}, g, '0);
        chk({tag, "_opfn"}, {fif.instrOp, fif.instrFunc}, {RTYPE, SLL});
    endtask

    initial begin
        ntests = 0;
        nfail = 0;
        last_exp = '0;
        mem_const = 1'b1;
        nRST = 1'b0;
        fif.ihit = 1'b1;
        fif.hazard = 1'b0;
        fif.branch = 1'b0;
        fif.jump = 1'b0;
        fif.branch_target = '0;
        fif.jump_target = '0;
        fif.halt = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        rst_checks("reset");
        nRST = 1'b1;

        // Straight-line fetch with a constant memory word
        step("seq0", 32'h0, 1'b1, 1, 32'h0);
        step("seq4", 32'h4, 1'b1, 1, 32'h4);
        chk("seq_op", fif.instrOp, 6'h08);

        // Hazard holds PC at 8 and freezes IF/ID at pc=4
        fif.hazard = 1'b1;
        step("haz1", 32'h8, 1'b1, 2, 32'h0);
        step("haz2", 32'h8, 1'b1, 2, 32'h0);
        step("haz3", 32'h8, 1'b1, 2, 32'h0);
        fif.hazard = 1'b0;
        step("seq8", 32'h8, 1'b1, 1, 32'h8);
        mem_const = 1'b0;

        // Jump with a hit: one bubble then the target
        fif.jump = 1'b1; fif.jump_target = 32'h40;
        step("jmp", 32'hC, 1'b1, 0, 32'h0);
        fif.jump = 1'b0;
        step("jmp_t", 32'h40, 1'b1, 1, 32'h40);

        // Branch during a 4-cycle miss: address stays at old PC
        fif.ihit = 1'b0; fif.branch = 1'b1; fif.branch_target = 32'h80;
        step("bmiss0", 32'h44, 1'b1, 0, 32'h0);
        fif.branch = 1'b0;
        step("bmiss1", 32'h44, 1'b1, 0, 32'h0);
        step("bmiss2", 32'h44, 1'b1, 0, 32'h0);
        step("bmiss3", 32'h44, 1'b1, 0, 32'h0);
        fif.ihit = 1'b1;
        step("bmiss_hit", 32'h44, 1'b1, 0, 32'h0);
        step("br_t", 32'h80, 1'b1, 1, 32'h80);

        // Jump+branch on a miss, then a later jump in DROP wins
        fif.ihit = 1'b0; fif.jump = 1'b1; fif.jump_target = 32'h100;
        fif.branch = 1'b1; fif.branch_target = 32'h200;
        step("jb_miss", 32'h84, 1'b1, 0, 32'h0);
        fif.branch = 1'b0; fif.jump_target = 32'h300;
        step("drop_jmp", 32'h84, 1'b1, 0, 32'h0);
        fif.jump = 1'b0; fif.ihit = 1'b1;
        step("drop_hit", 32'h84, 1'b1, 0, 32'h0);
        step("late_t", 32'h300, 1'b1, 1, 32'h300);

        // Jump+branch on a hit, unaligned jump target is masked
        fif.jump = 1'b1; fif.jump_target = 32'h103;
        fif.branch = 1'b1; fif.branch_target = 32'h200;
        step("jb_hit", 32'h304, 1'b1, 0, 32'h0);
        fif.jump = 1'b0; fif.branch = 1'b0;
        step("jb_t", 32'h100, 1'b1, 1, 32'h100);

        // Hazard and branch together: redirect wins, IF/ID flushed
        fif.hazard = 1'b1; fif.branch = 1'b1; fif.branch_target = 32'h20;
        step("hz_br", 32'h104, 1'b1, 0, 32'h0);
        fif.hazard = 1'b0; fif.branch = 1'b0;
        step("hz_br_t", 32'h20, 1'b1, 1, 32'h20);

        // PC+4 wraps at the top of the address space
        fif.jump = 1'b1; fif.jump_target = 32'hFFFF_FFFC;
        step("wrap_j", 32'h24, 1'b1, 0, 32'h0);
        fif.jump = 1'b0;
        step("wrap_top", 32'hFFFF_FFFC, 1'b1, 1, 32'hFFFF_FFFC);
        step("wrap_0", 32'h0, 1'b1, 1, 32'h0);

        // Halt with a hit drops the word and stops fetching for good
        fif.halt = 1'b1;
        step("halt", 32'h4, 1'b1, 0, 32'h0);
        fif.halt = 1'b0;
        step("halted1", 32'h4, 1'b0, 0, 32'h0);
        step("halted2", 32'h4, 1'b0, 0, 32'h0);

        // Reset pulse mid-halt restarts from PC_INIT
        nRST = 1'b0;
        #1;
        rst_checks("rst2");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        step("restart0", 32'h0, 1'b1, 1, 32'h0);
        step("restart4", 32'h4, 1'b1, 1, 32'h4);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
